// File: rtl/boot_stream_ctrl.sv
// Boot-data sequencer: accepts 32-bit host words over a four-phase req/ack
// handshake and streams them MSB-byte-first to the loader, gated by sync byte and ROM size.
module boot_stream_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h4E
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic [31:0] rom_size,
  input  logic [31:0] host_bootdata,
  input  logic        host_bootdata_req,
  output logic        host_bootdata_ack,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        synced,
  output logic        done,
  output logic [31:0] bytes_loaded
);

  typedef enum logic [1:0] {IDLE, UNPACK, EMIT} state_t;

  state_t      state;
  logic [31:0] word_q;
  logic [1:0]  slot;

  logic [7:0]  cur_byte;
  logic        in_range;
  logic        take;
  logic        bl_inc;
  logic [31:0] bl_next;

  // Slot 0 is the most significant byte of the latched word.
  always_comb begin
    cur_byte = word_q[31:24];
    case (slot)
      2'd0: cur_byte = word_q[31:24];
      2'd1: cur_byte = word_q[23:16];
      2'd2: cur_byte = word_q[15:8];
      2'd3: cur_byte = word_q[7:0];
      default: cur_byte = word_q[31:24];
    endcase
  end

  // Bytes past rom_size are not counted, so the counter saturates there.
  always_comb begin
    in_range = (bytes_loaded < rom_size);
    take     = in_range && (synced || (cur_byte == SYNC_BYTE));
    bl_inc   = (state == UNPACK) && in_range;
    bl_next  = bl_inc ? (bytes_loaded + 32'd1) : bytes_loaded;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      word_q            <= '0;
      slot              <= '0;
      host_bootdata_ack <= 1'b0;
      byte_data         <= '0;
      byte_valid        <= 1'b0;
      synced            <= 1'b0;
      done              <= 1'b0;
      bytes_loaded      <= '0;
    end else if (restart) begin
      state             <= IDLE;
      word_q            <= '0;
      slot              <= '0;
      host_bootdata_ack <= 1'b0;
      byte_data         <= '0;
      byte_valid        <= 1'b0;
      synced            <= 1'b0;
      done              <= 1'b0;
      bytes_loaded      <= '0;
    end else begin
      if (!host_bootdata_req)
        host_bootdata_ack <= 1'b0;

      bytes_loaded <= bl_next;
      done         <= done | (bl_next >= rom_size);

      case (state)
        IDLE: begin
          // Acceptance needs ack low so each word gets a full four-phase cycle.
          if (host_bootdata_req && !host_bootdata_ack) begin
            word_q            <= host_bootdata;
            host_bootdata_ack <= 1'b1;
            slot              <= 2'd0;
            state             <= UNPACK;
          end
        end
        UNPACK: begin
          if (take) begin
            byte_data  <= cur_byte;
            byte_valid <= 1'b1;
            synced     <= 1'b1;
            state      <= EMIT;
          end else begin
            slot  <= slot + 2'd1;
            state <= (slot == 2'd3) ? IDLE : UNPACK;
          end
        end
        EMIT: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            slot       <= slot + 2'd1;
            state      <= (slot == 2'd3) ? IDLE : UNPACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_stream_ctrl.sv
// Scoreboard bench for boot_stream_ctrl: a stream-level model queues expected
// loader bytes per host word; a monitor pops them on every valid/ready handshake.
module tb_boot_stream_ctrl;

  localparam logic [7:0] SYNC = 8'h4E;

  logic        clk;
  logic        reset_n;
  logic        restart;
  logic [31:0] rom_size;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        synced;
  logic        done;
  logic [31:0] bytes_loaded;

  boot_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .rom_size(rom_size),
    .host_bootdata(host_bootdata), .host_bootdata_req(host_bootdata_req),
    .host_bootdata_ack(host_bootdata_ack), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .synced(synced),
    .done(done), .bytes_loaded(bytes_loaded)
  );

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 1;  // 0 random, 1 high, 2 low

  logic [7:0]  exp_q[$];
  int unsigned m_rom;
  int unsigned m_pos;      // position of next byte in the host stream
  bit          m_synced;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream view: only positions below rom_size exist; from the first sync byte on,
  // every existing byte goes to the loader.
  function automatic void model_word(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[31 - 8*i -: 8];
      if (m_pos < m_rom) begin
        m_pos++;
        if (!m_synced && b == SYNC) m_synced = 1'b1;
        if (m_synced) exp_q.push_back(b);
      end
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_pos    = 0;
    m_synced = 1'b0;
  endfunction

  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: byte_ready = ($urandom_range(0, 1) == 1);
        1: byte_ready = 1'b1;
        default: byte_ready = 1'b0;
      endcase
    end
  end

  // Monitor: the handshake completes on the next rising edge.
  initial begin
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, byte_valid}, 32'd1);
        chk("hold_data", {24'd0, byte_data}, {24'd0, prev_data});
      end
      if (reset_n && !restart && byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL byte_unexpected: got %0h want none", byte_data);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", {24'd0, byte_data}, {24'd0, e});
        end
      end
      prev_hold = reset_n && !restart && byte_valid && !byte_ready;
      prev_data = byte_data;
    end
  end

  task automatic do_reset(input int unsigned rs);
    rom_size          = rs;
    m_rom             = rs;
    reset_n           = 1'b0;
    restart           = 1'b0;
    host_bootdata_req = 1'b0;
    host_bootdata     = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack_low();
    int n = 0;
    while (host_bootdata_ack && n < 300) begin @(posedge clk); #1; n++; end
    chk("ack_fall", {31'd0, host_bootdata_ack}, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit lat_chk);
    int n = 0;
    model_word(w);
    host_bootdata     = w;
    host_bootdata_req = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!host_bootdata_ack && n < 300);
    chk("ack_rise", {31'd0, host_bootdata_ack}, 32'd1);
    host_bootdata_req = 1'b0;
    if (lat_chk) begin
      @(posedge clk); #1;
      chk("lat_valid", {31'd0, byte_valid}, 32'd1);
      chk("lat_data", {24'd0, byte_data}, {24'd0, w[31:24]});
    end
    wait_ack_low();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("drain", exp_q.size(), 32'd0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic end_check(input string tag);
    chk({tag, "_loaded"}, bytes_loaded, m_pos);
    chk({tag, "_synced"}, {31'd0, synced}, {31'd0, m_synced});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, (m_pos >= m_rom)});
  endtask

  initial begin
    logic [31:0] w;
    int n;
    rdy_mode = 1;

    // Reset with req held high; ack must follow release by one edge.
    rom_size = 32'd8; m_rom = 8; model_clear();
    reset_n = 1'b0; restart = 1'b0;
    host_bootdata = 32'h01020304; host_bootdata_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, host_bootdata_ack}, 32'd0);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_loaded", bytes_loaded, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_ack", {31'd0, host_bootdata_ack}, 32'd1);
    model_word(32'h01020304);
    host_bootdata_req = 1'b0;
    wait_ack_low();
    drain();
    end_check("rst");

    // Sync skip with backpressure on the sync byte.
    do_reset(16);
    rdy_mode = 2; byte_ready = 1'b0;
    send_word(32'h00114E45, 1'b0);
    n = 0;
    while (!byte_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid_up", {31'd0, byte_valid}, 32'd1);
    chk("bp_synced", {31'd0, synced}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, byte_data}, 32'h4E);
    end
    rdy_mode = 1; byte_ready = 1'b1;
    drain();
    end_check("sync");

    // Truncation to rom_size=6, third word swallowed.
    do_reset(6);
    send_word(32'h4E45531A, 1'b1);
    send_word(32'hAABBCCDD, 1'b0);
    drain();
    end_check("trunc");
    send_word(32'h4E4E4E4E, 1'b0);
    drain();
    end_check("trunc3");

    // Four-phase handshake with req held past ack.
    do_reset(16);
    model_word(32'h4E010203);
    host_bootdata = 32'h4E010203; host_bootdata_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!host_bootdata_ack && n < 50);
    chk("hs_ack", {31'd0, host_bootdata_ack}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hs_ack_held", {31'd0, host_bootdata_ack}, 32'd1);
    end
    host_bootdata_req = 1'b0;
    @(posedge clk); #1;
    chk("hs_ack_drop", {31'd0, host_bootdata_ack}, 32'd0);
    host_bootdata = 32'h4E999999;
    repeat (10) @(posedge clk);
    #1;
    chk("hs_no_take", {31'd0, host_bootdata_ack}, 32'd0);
    send_word(32'h04050607, 1'b1);
    drain();
    end_check("hs");

    // Restart while a byte is stalled on the loader.
    do_reset(16);
    rdy_mode = 2; byte_ready = 1'b0;
    send_word(32'h4E112233, 1'b1);
    restart = 1'b1;
    model_clear();
    @(posedge clk); #1;
    restart = 1'b0;
    chk("rs_valid", {31'd0, byte_valid}, 32'd0);
    chk("rs_synced", {31'd0, synced}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    chk("rs_loaded", bytes_loaded, 32'd0);
    rdy_mode = 1; byte_ready = 1'b1;
    send_word(32'h11224E33, 1'b0);
    drain();
    end_check("rs");

    // Zero-size ROM: done on the first edge after release.
    do_reset(0);
    chk("z_done", {31'd0, done}, 32'd1);
    send_word(32'h4E4E0000, 1'b0);
    drain();
    end_check("zero");

    // Randomized streams with random ready and req gaps.
    for (int it = 0; it < 6; it++) begin
      do_reset($urandom_range(0, 28));
      rdy_mode = 0;
      for (int k = 0; k < 9; k++) begin
        for (int b = 0; b < 4; b++)
          w[31 - 8*b -: 8] = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
        send_word(w, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      rdy_mode = 1;
      drain();
      end_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
